// File: rtl/display_scanner_pkg.sv
// display_pkg: shared FSM state type, colour constants and default geometry
// for the display_scanner frame painter.
package display_pkg;

  // Default screen geometry (grid columns and rows)
  localparam int DEFAULT_WIDTH  = 160;
  localparam int DEFAULT_HEIGHT = 120;

  // 3-bit RGB colour constants
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] BLACK = 3'b000;

  // Frame painter states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SPRITE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/display_scanner_raster_counter.sv
// raster_counter: walks (cx, cy) in raster order together with the linear bit
// index of the cell. The index is kept incrementally (+1 per cell), never
// multiplied. Outputs show the successor cell so the painter can register it
// into its pixel outputs on the same edge that advances the counter.
module raster_counter
  import display_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int HEIGHT = DEFAULT_HEIGHT,
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int IW     = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic [IW-1:0] next_idx,
  output logic          last
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] cx_reg;
  logic [YW-1:0] cy_reg;
  logic [IW-1:0] idx_reg;
  logic          x_wrap;

  // Successor cell: wrap x at WIDTH, y at HEIGHT, index back to 0 after the last cell
  always_comb begin
    x_wrap   = (cx_reg == X_LAST);
    last     = x_wrap && (cy_reg == Y_LAST);
    next_x   = x_wrap ? '0 : cx_reg + 1'b1;
    next_y   = x_wrap ? ((cy_reg == Y_LAST) ? '0 : cy_reg + 1'b1) : cy_reg;
    next_idx = last ? '0 : idx_reg + 1'b1;
  end

  // Counter state: clear wins over advance so a new frame always starts at (0,0)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx_reg  <= '0;
      cy_reg  <= '0;
      idx_reg <= '0;
    end else if (clear) begin
      cx_reg  <= '0;
      cy_reg  <= '0;
      idx_reg <= '0;
    end else if (advance) begin
      cx_reg  <= next_x;
      cy_reg  <= next_y;
      idx_reg <= next_idx;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// display_scanner: frame painter between the game-state logic and the VGA
// adapter. Each frame writes every bullet-grid cell in raster order, then the
// ship sprites on top, using a plot/ready handshake and a one-cycle done pulse.
// Build option: define SKIP_BG_EN to suppress writes for clear grid cells
// (they still cost one cycle each, so frame timing is unchanged).
module display_scanner
  import display_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HEIGHT      = DEFAULT_HEIGHT,
  parameter int XW          = 8,
  parameter int YW          = 7,
  parameter int CW          = 3,
  parameter int NUM_SPRITES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH*HEIGHT-1:0]   grid,
  input  logic [NUM_SPRITES*XW-1:0] sprite_x,
  input  logic [NUM_SPRITES*YW-1:0] sprite_y,
  input  logic [NUM_SPRITES*CW-1:0] sprite_colour,
  input  logic [CW-1:0]             bullet_colour,
  input  logic [CW-1:0]             bg_colour,
  input  logic                      ready,
  output logic [XW-1:0]             x,
  output logic [YW-1:0]             y,
  output logic [CW-1:0]             colour,
  output logic                      plot,
  output logic                      busy,
  output logic                      done
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int SW   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_SPRITES - 1);
  localparam logic [XW:0]   X_LIM     = (XW + 1)'(WIDTH);
  localparam logic [YW:0]   Y_LIM     = (YW + 1)'(HEIGHT);

  state_t                    state_reg;
  logic [SW-1:0]             slot_reg;
  logic [NUM_SPRITES*XW-1:0] sx_reg;
  logic [NUM_SPRITES*YW-1:0] sy_reg;
  logic [NUM_SPRITES*CW-1:0] sc_reg;
  logic [XW-1:0]             x_reg;
  logic [YW-1:0]             y_reg;
  logic [CW-1:0]             colour_reg;
  logic                      plot_reg;
  logic                      busy_reg;
  logic                      done_reg;

  // Raster counter interface
  logic          cnt_clear;
  logic          cnt_advance;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic [IW-1:0] next_idx;
  logic          last_cell;

  // Presentation helpers
  logic          step;
  logic [SW-1:0] pres_slot;
  int            slot_idx;
  logic [XW-1:0] sel_x;
  logic [YW-1:0] sel_y;
  logic [CW-1:0] sel_colour;
  logic          sel_on;
  logic [CW-1:0] first_colour;
  logic          first_plot;
  logic [CW-1:0] next_colour;
  logic          next_plot;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW),
    .IW     (IW)
  ) u_raster (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .advance  (cnt_advance),
    .next_x   (next_x),
    .next_y   (next_y),
    .next_idx (next_idx),
    .last     (last_cell)
  );

  // A presented pixel moves on when accepted; a suppressed one (plot=0) moves on at once
  always_comb begin
    step        = plot_reg ? ready : 1'b1;
    cnt_clear   = (state_reg == IDLE) && start;
    cnt_advance = (state_reg == SCAN) && step && !last_cell;
  end

  // Sprite slot about to be presented: slot 0 when leaving the scan, else the next slot
  always_comb begin
    pres_slot  = (state_reg == SPRITE) ? slot_reg + 1'b1 : '0;
    slot_idx   = int'(pres_slot);
    sel_x      = sx_reg[slot_idx*XW +: XW];
    sel_y      = sy_reg[slot_idx*YW +: YW];
    sel_colour = sc_reg[slot_idx*CW +: CW];
    // Unsigned compare; off-screen slots are shown with plot=0 for one cycle
    sel_on     = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
  end

  // Cell colour/plot for the first cell of a frame and for the successor cell
  always_comb begin
`ifdef SKIP_BG_EN
    first_colour = bullet_colour;
    first_plot   = grid[0];
    next_colour  = bullet_colour;
    next_plot    = grid[next_idx];
`else
    first_colour = grid[0] ? bullet_colour : bg_colour;
    first_plot   = 1'b1;
    next_colour  = grid[next_idx] ? bullet_colour : bg_colour;
    next_plot    = 1'b1;
`endif
  end

  // Frame FSM with registered pixel outputs, busy and done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      slot_reg   <= '0;
      sx_reg     <= '0;
      sy_reg     <= '0;
      sc_reg     <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      plot_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Sprites are snapshotted; the grid is read live and must be held by the caller
            sx_reg     <= sprite_x;
            sy_reg     <= sprite_y;
            sc_reg     <= sprite_colour;
            state_reg  <= SCAN;
            busy_reg   <= 1'b1;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= first_colour;
            plot_reg   <= first_plot;
          end
        end
        SCAN: begin
          if (step) begin
            if (last_cell) begin
              state_reg  <= SPRITE;
              slot_reg   <= '0;
              x_reg      <= sel_x;
              y_reg      <= sel_y;
              colour_reg <= sel_colour;
              plot_reg   <= sel_on;
            end else begin
              x_reg      <= next_x;
              y_reg      <= next_y;
              colour_reg <= next_colour;
              plot_reg   <= next_plot;
            end
          end
        end
        SPRITE: begin
          if (step) begin
            if (slot_reg == SLOT_LAST) begin
              state_reg <= DONE;
              plot_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              slot_reg   <= pres_slot;
              x_reg      <= sel_x;
              y_reg      <= sel_y;
              colour_reg <= sel_colour;
              plot_reg   <= sel_on;
            end
          end
        end
        DONE: begin
          // start in this cycle is deliberately not looked at
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          plot_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign x      = x_reg;
  assign y      = y_reg;
  assign colour = colour_reg;
  assign plot   = plot_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed and randomised frames on a 4x3 grid, checked
// against a write-list model built from the grid and sprite rules.
module tb_display_scanner;
  import display_pkg::*;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int CW = 3;
  localparam int NS = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [W*H-1:0]    grid = '0;
  logic [NS*XW-1:0]  sprite_x = '0;
  logic [NS*YW-1:0]  sprite_y = '0;
  logic [NS*CW-1:0]  sprite_colour = '0;
  logic [CW-1:0]     bullet_colour = GREEN;
  logic [CW-1:0]     bg_colour = BLACK;
  logic              ready = 1'b1;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [CW-1:0]     colour;
  logic              plot;
  logic              busy;
  logic              done;

  int compared = 0;
  int mismatched = 0;
  int exp_q[$];
  int act_q[$];

  always #10 clk = ~clk;

  display_scanner #(
    .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .CW(CW), .NUM_SPRITES(NS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .grid(grid),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_colour(sprite_colour),
    .bullet_colour(bullet_colour), .bg_colour(bg_colour), .ready(ready),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(input int px, input int py, input int pc);
    return (px << 8) | (py << 4) | pc;
  endfunction

  task automatic set_sprite(input int s, input int sx, input int sy, input logic [CW-1:0] sc);
    sprite_x[s*XW +: XW]      = XW'(sx);
    sprite_y[s*YW +: YW]      = YW'(sy);
    sprite_colour[s*CW +: CW] = sc;
  endtask

  // Expected write list: every cell in raster order, then on-screen sprites by slot
  task automatic build_model();
    exp_q.delete();
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        bit set;
        set = grid[yy*W + xx];
`ifdef SKIP_BG_EN
        if (set) exp_q.push_back(enc(xx, yy, int'(bullet_colour)));
`else
        exp_q.push_back(enc(xx, yy, set ? int'(bullet_colour) : int'(bg_colour)));
`endif
      end
    end
    for (int s = 0; s < NS; s++) begin
      int sx, sy, sc;
      sx = int'(sprite_x[s*XW +: XW]);
      sy = int'(sprite_y[s*YW +: YW]);
      sc = int'(sprite_colour[s*CW +: CW]);
      if (sx < W && sy < H) exp_q.push_back(enc(sx, sy, sc));
    end
  endtask

  // One frame: start pulse, per-cycle collection of accepted writes, then list compare
  task automatic run_frame(input int stall_len, input bit rnd_ready,
                           input bit busy_start, input bit done_start,
                           output int stalls);
    int          stall_left;
    bit          hold;
    bit          got_done;
    logic [31:0] prev;
    build_model();
    act_q.delete();
    stalls     = 0;
    stall_left = stall_len;
    hold       = 1'b0;
    got_done   = 1'b0;
    prev       = '0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_plot", plot, 0);
    start = 1'b1;
    for (int cyc = 1; cyc <= 300 && !got_done; cyc++) begin
      @(negedge clk);
      start = busy_start && (cyc == 5);
      if (hold) check("hold_stable", {x, y, colour, plot}, prev);
      if (rnd_ready) ready = ($urandom_range(3) != 0);
      else if (stall_left > 0 && plot && x == 2 && y == 0) begin
        ready = 1'b0;
        stall_left--;
      end else ready = 1'b1;
      hold = plot && !ready;
      if (hold) stalls++;
      prev = {x, y, colour, plot};
      if (plot && ready) act_q.push_back(enc(int'(x), int'(y), int'(colour)));
      check("busy_in_frame", busy, 1);
      if (done) begin
        got_done = 1'b1;
        check("frame_len", cyc, 1 + W*H + NS + stalls);
        if (done_start) start = 1'b1;
      end
    end
    check("done_seen", got_done, 1);
    if (!rnd_ready) check("stall_count", stalls, stall_len);
    ready = 1'b1;
    if (done_start) begin
      @(negedge clk);
      start = 1'b0;
      check("done_start_ignored", busy, 0);
      @(negedge clk);
      check("still_idle", busy, 0);
    end
    check("n_writes", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("write%0d", i), act_q[i], exp_q[i]);
    $display("frame grid=%03h writes=%0d stalls=%0d", grid, act_q.size(), stalls);
  endtask

  initial begin
    int st;
    int cq[$];
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;

    // Scan order, colours and sprite overwrite at (1,1)
    grid = 12'b0000_0010_0001;
    set_sprite(0, 1, 1, RED);
    set_sprite(1, 1, 1, BLUE);
    run_frame(0, 1'b0, 1'b0, 1'b0, st);
    cq.delete();
    foreach (act_q[i]) if ((act_q[i] >> 4) == ((1 << 4) | 1)) cq.push_back(act_q[i] & 7);
`ifdef SKIP_BG_EN
    check("ovr_count", cq.size(), 3);
`else
    check("ovr_count", cq.size(), 3);
`endif
    if (cq.size() >= 3) begin
      check("ovr_first", cq[cq.size()-3], GREEN);
      check("ovr_mid", cq[cq.size()-2], RED);
      check("ovr_last", cq[cq.size()-1], BLUE);
    end

    // Back-pressure: five stall cycles while (2,0) is presented
    grid = 12'b1010_0101_0110;
    set_sprite(0, 3, 2, RED);
    set_sprite(1, 0, 0, BLUE);
    run_frame(5, 1'b0, 1'b0, 1'b0, st);

    // Off-screen slot 1 (x=4)
    grid = 12'b0000_0010_0001;
    set_sprite(0, 2, 1, RED);
    set_sprite(1, 4, 0, BLUE);
    run_frame(0, 1'b0, 1'b0, 1'b0, st);

    // Start while busy and in the done cycle are ignored
    set_sprite(1, 0, 3, BLUE);
    run_frame(0, 1'b0, 1'b1, 1'b1, st);

    // Reset mid-frame at cell 6
    set_sprite(1, 3, 0, BLUE);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_x", x, 2);
    check("pre_rst_y", y, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_plot", plot, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_x", x, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | done | plot | busy;
    end
    check("no_activity_after_rst", seen, 0);
    $display("reset mid-frame done");
    run_frame(0, 1'b0, 1'b0, 1'b0, st);

    // Randomised frames, alternating steady and random ready
    for (int f = 0; f < 8; f++) begin
      grid = W*H'($urandom);
      for (int s = 0; s < NS; s++)
        set_sprite(s, $urandom_range(5), $urandom_range(3), CW'($urandom));
      bullet_colour = CW'($urandom);
      bg_colour     = CW'($urandom);
      run_frame(0, f[0], 1'b0, 1'b0, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Parametrised frame painter between the game-state logic and the VGA adapter.
- On each `start`, it walks the full bullet grid in raster order and emits one pixel write per cell: bullet colour if the bit is set, background colour if not.
- It then draws NUM_SPRITES ship sprites on top.
- Pixel writes are registered, use a `ready` back-pressure handshake, and report completion with `done`.

Parameters:
- WIDTH, 160, grid columns.
- HEIGHT, 120, grid rows.
- XW, 8, x coordinate width; must satisfy 2^XW >= WIDTH.
- YW, 7, y coordinate width; must satisfy 2^YW >= HEIGHT.
- CW, 3, colour width.
- NUM_SPRITES, 2, sprite slots (slot 0 = user, slot 1 = enemy).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to paint a frame; ignored while busy.
- grid  in  WIDTH*HEIGHT  bullet bitmap; cell (x,y) is bit y*WIDTH+x.
- sprite_x  in  NUM_SPRITES*XW  packed x per slot; slot i uses bits [i*XW +: XW].
- sprite_y  in  NUM_SPRITES*YW  packed y per slot.
- sprite_colour  in  NUM_SPRITES*CW  packed colour per slot.
- bullet_colour  in  CW  colour for set grid cells (default wiring 3'b010).
- bg_colour  in  CW  colour for clear grid cells (default wiring 3'b000).
- ready  in  1  VGA adapter accepts the write this cycle.
- x  out  XW  pixel x.
- y  out  YW  pixel y.
- colour  out  CW  pixel colour.
- plot  out  1  x, y and colour are valid.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async, reset==0): state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; all counters 0. Reset mid-frame abandons the frame with no done pulse.
- Transfer: occurs on a clock edge where plot && ready. While plot=1 && ready=0, x, y, colour and plot hold stable.
- FSM states: IDLE, SCAN, SPRITE, DONE.
- IDLE, start=1:
  - Latch sprite_x, sprite_y and sprite_colour into shadow registers. The grid is NOT latched; the caller holds it stable while busy.
  - Go to SCAN with cx=0, cy=0.
  - First pixel presented the next cycle: plot=1, (0,0), colour per grid bit 0.
  - busy=1 from the cycle after start until the done cycle inclusive.
- SCAN:
  - Present cell (cx,cy) with colour = grid[cy*WIDTH+cx] ? bullet_colour : bg_colour.
  - On transfer, advance cx. When cx==WIDTH-1, wrap cx to 0 and increment cy.
  - The transfer of (WIDTH-1, HEIGHT-1) moves to SPRITE with slot=0.
- SPRITE:
  - Present slot s from the shadow registers.
  - If the shadow x >= WIDTH or y >= HEIGHT, the slot is off-screen: plot=0 and it advances unconditionally after one cycle.
  - Otherwise it advances on transfer.
  - After slot NUM_SPRITES-1, go to DONE.
- DONE: plot=0, done=1 for exactly one cycle, then IDLE with busy=0.
- start while busy has no effect.
- start in the DONE cycle is ignored. start on the first IDLE cycle after DONE is accepted, so back-to-back frames are possible.
- Latency with ready tied high: exactly WIDTH*HEIGHT + NUM_SPRITES cycles from the first plot to the done cycle, minus nothing. Off-screen slots still cost one cycle.
- Priority: sprites are drawn after the grid, so they overwrite a bullet at the same position. A higher slot index overwrites a lower one at the same position.
- Arithmetic:
  - The bit index is an integer of width clog2(WIDTH*HEIGHT), maintained incrementally: +1 per cell, reset to 0 at frame start. It is never multiplied.
  - Sprite comparisons are unsigned.

Optional Feature:
- SKIP_BG_EN defined:
  - In SCAN, clear cells present plot=0 and advance unconditionally in one cycle; only set cells produce writes. bg_colour is unused.
  - Frame cycle count with ready high is unchanged.
  - The caller must clear the screen by other means.
- Not defined: every cell is written as specified above.

Decomposition:
- Package display_pkg holds:
  - the state enum (IDLE, SCAN, SPRITE, DONE);
  - colour constants RED=3'b100, GREEN=3'b010, BLUE=3'b001, BLACK=3'b000;
  - default WIDTH/HEIGHT localparams.
- One natural sub-module, raster_counter: cx/cy/bit-index counter with advance and clear inputs, wrap at WIDTH and HEIGHT, and a last-cell flag.

Test Plan:
- Use WIDTH=4, HEIGHT=3, NUM_SPRITES=2 and ready=1 unless stated.
- Scan order and colours: grid=12'b0000_0010_0001, start pulse -> 12 writes in raster order. (0,0) and (1,1) are GREEN; the other ten are BLACK. Then the sprites follow; done occurs 14 cycles after the first plot.
- Sprite overwrite: sprite0=(1,1,RED), sprite1=(1,1,BLUE) -> the final three writes to (1,1) are GREEN, RED, BLUE in that order.
- Back-pressure: ready low for 5 cycles while (2,0) is presented -> x=2, y=0 and colour are held stable, no counter advance, total frame length grows by 5.
- Off-screen sprite: sprite1 x=4 -> slot 1 has plot=0 for one cycle; done is still at cycle 14; no write has x>=4.
- Start while busy, and reset mid-frame: start during SCAN is ignored. Reset asserted at cell 6 -> immediately plot=0, busy=0, done never pulses. The next start begins again at (0,0).
- SKIP_BG_EN build: same grid as the scan-order test -> exactly 4 writes: (0,0) GREEN, (1,1) GREEN, then the two sprites; done at cycle 14.
